// File: rtl/ps2_letter_decoder_if.sv
// Bus between the raw PS/2 lines, the letter decoder and the hangman datapath.
// The master side drives the keyboard lines and consumes the decoded events.
interface ps2_letter_decoder_if;
    logic       i_ps2_clk;
    logic       i_ps2_dat;
    logic [4:0] o_char_out;
    logic       o_char_valid;
    logic       o_enter;
    logic       o_backspace;
    logic       o_frame_err;
    logic [7:0] o_last_scan;

    modport master (
        output i_ps2_clk, i_ps2_dat,
        input  o_char_out, o_char_valid, o_enter, o_backspace, o_frame_err, o_last_scan
    );

    modport slave (
        input  i_ps2_clk, i_ps2_dat,
        output o_char_out, o_char_valid, o_enter, o_backspace, o_frame_err, o_last_scan
    );
endinterface

// File: rtl/ps2_letter_decoder.sv
// PS/2 keyboard receiver that turns letter make-codes into 1..26 guess codes,
// emits Enter/Backspace pulses and swallows break, extended and typematic bytes.
module ps2_letter_decoder #(
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic clk,
    input  logic resetn,
    ps2_letter_decoder_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rxState_t;
    typedef enum logic [1:0] {BY_NORMAL, BY_BREAK, BY_EXT, BY_EXT_BREAK} byteState_t;

    logic [1:0]  r_clkSync;
    logic [1:0]  r_datSync;
    logic        r_clkPrev;
    logic        w_fall;
    logic        w_dat;

    rxState_t    r_rxState;
    logic [7:0]  r_shift;
    logic [2:0]  r_bitCnt;
    logic        r_parity;
    logic [TW-1:0] r_timeout;
    logic        r_byteReady;
    logic        r_frameErr;
    logic [7:0]  r_lastScan;

    byteState_t  r_byteState;
    logic [7:0]  r_held;
    logic [4:0]  r_charOut;
    logic        r_charValid;
    logic        r_enter;
    logic        r_backspace;
    logic [4:0]  w_letter;

    // Synchronisers reset to the idle-high line level so release never fakes an edge
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_clkSync <= 2'b11;
            r_datSync <= 2'b11;
            r_clkPrev <= 1'b1;
        end else begin
            r_clkSync <= {r_clkSync[0], bus.i_ps2_clk};
            r_datSync <= {r_datSync[0], bus.i_ps2_dat};
            r_clkPrev <= r_clkSync[1];
        end
    end

    assign w_fall = r_clkPrev & ~r_clkSync[1];
    assign w_dat  = r_datSync[1];

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_rxState   <= RX_IDLE;
            r_shift     <= 8'h00;
            r_bitCnt    <= 3'd0;
            r_parity    <= 1'b0;
            r_timeout   <= '0;
            r_byteReady <= 1'b0;
            r_frameErr  <= 1'b0;
            r_lastScan  <= 8'h00;
        end else begin
            r_byteReady <= 1'b0;
            r_frameErr  <= 1'b0;
            if (w_fall) begin
                r_timeout <= '0;
                case (r_rxState)
                    RX_IDLE: begin
                        if (!w_dat) begin
                            r_rxState <= RX_DATA;
                            r_bitCnt  <= 3'd0;
                        end
                    end
                    RX_DATA: begin
                        r_shift <= {w_dat, r_shift[7:1]};
                        if (r_bitCnt == 3'd7) begin
                            r_rxState <= RX_PARITY;
                        end else begin
                            r_bitCnt <= r_bitCnt + 3'd1;
                        end
                    end
                    RX_PARITY: begin
                        r_parity  <= w_dat;
                        r_rxState <= RX_STOP;
                    end
                    RX_STOP: begin
                        r_rxState <= RX_IDLE;
                        if (w_dat && (^{r_shift, r_parity})) begin
                            r_byteReady <= 1'b1;
                            r_lastScan  <= r_shift;
                        end else begin
                            r_frameErr <= 1'b1;
                        end
                    end
                endcase
            end else if (r_rxState == RX_IDLE) begin
                r_timeout <= '0;
            end else if (r_timeout == TW'(TIMEOUT_CYCLES)) begin
                r_rxState  <= RX_IDLE;
                r_frameErr <= 1'b1;
                r_timeout  <= '0;
            end else begin
                r_timeout <= r_timeout + TW'(1);
            end
        end
    end

    // Letter scan code to guess code; zero marks a non-letter key
    always_comb begin
        w_letter = 5'd0;
        case (r_lastScan)
            8'h1C: w_letter = 5'd1;
            8'h32: w_letter = 5'd2;
            8'h21: w_letter = 5'd3;
            8'h23: w_letter = 5'd4;
            8'h24: w_letter = 5'd5;
            8'h2B: w_letter = 5'd6;
            8'h34: w_letter = 5'd7;
            8'h33: w_letter = 5'd8;
            8'h43: w_letter = 5'd9;
            8'h3B: w_letter = 5'd10;
            8'h42: w_letter = 5'd11;
            8'h4B: w_letter = 5'd12;
            8'h3A: w_letter = 5'd13;
            8'h31: w_letter = 5'd14;
            8'h44: w_letter = 5'd15;
            8'h4D: w_letter = 5'd16;
            8'h15: w_letter = 5'd17;
            8'h2D: w_letter = 5'd18;
            8'h1B: w_letter = 5'd19;
            8'h2C: w_letter = 5'd20;
            8'h3C: w_letter = 5'd21;
            8'h2A: w_letter = 5'd22;
            8'h1D: w_letter = 5'd23;
            8'h22: w_letter = 5'd24;
            8'h35: w_letter = 5'd25;
            8'h1A: w_letter = 5'd26;
            default: w_letter = 5'd0;
        endcase
    end

    // r_held remembers the key currently down so typematic repeats are dropped
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_byteState <= BY_NORMAL;
            r_held      <= 8'h00;
            r_charOut   <= 5'd0;
            r_charValid <= 1'b0;
            r_enter     <= 1'b0;
            r_backspace <= 1'b0;
        end else begin
            r_charValid <= 1'b0;
            r_enter     <= 1'b0;
            r_backspace <= 1'b0;
            if (r_byteReady) begin
                case (r_byteState)
                    BY_NORMAL: begin
                        if (r_lastScan == 8'hF0) begin
                            r_byteState <= BY_BREAK;
                        end else if (r_lastScan == 8'hE0) begin
                            r_byteState <= BY_EXT;
                        end else if (r_lastScan != r_held) begin
                            r_held <= r_lastScan;
                            if (w_letter != 5'd0) begin
                                r_charOut   <= w_letter;
                                r_charValid <= 1'b1;
                            end else if (r_lastScan == 8'h5A) begin
                                r_enter <= 1'b1;
                            end else if (r_lastScan == 8'h66) begin
                                r_backspace <= 1'b1;
                            end
                        end
                    end
                    BY_BREAK: begin
                        if (r_lastScan == r_held) begin
                            r_held <= 8'h00;
                        end
                        r_byteState <= BY_NORMAL;
                    end
                    BY_EXT: begin
                        r_byteState <= (r_lastScan == 8'hF0) ? BY_EXT_BREAK : BY_NORMAL;
                    end
                    BY_EXT_BREAK: begin
                        r_byteState <= BY_NORMAL;
                    end
                endcase
            end
        end
    end

    assign bus.o_char_out   = r_charOut;
    assign bus.o_char_valid = r_charValid;
    assign bus.o_enter      = r_enter;
    assign bus.o_backspace  = r_backspace;
    assign bus.o_frame_err  = r_frameErr;
    assign bus.o_last_scan  = r_lastScan;
endmodule

// File: tb/tb_ps2_letter_decoder.sv
// Self-checking bench for ps2_letter_decoder: a table of single-frame vectors
// plus hand-written latency, timeout and mid-frame reset sequences.
module tb_ps2_letter_decoder;
    localparam int TIMEOUT = 5000;
    localparam int HALF    = 8;

    typedef struct {
        logic [7:0] scan;
        bit         parOk;
        bit         stopOk;
        int         dCv;
        int         dEn;
        int         dBs;
        int         dErr;
        int         expChar;
        int         expLast;
    } vec_t;

    logic clk;
    logic resetn;
    ps2_letter_decoder_if bus();

    ps2_letter_decoder #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    int total = 0;
    int bad = 0;
    int cycleCount = 0;
    int cvCount = 0;
    int enCount = 0;
    int bsCount = 0;
    int errCount = 0;
    int exclBad = 0;
    int lastCvCycle = 0;
    int stopFallCycle = 0;
    vec_t vecs[$];

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cycleCount++;

    // Pulse monitor: counts high cycles of every event output
    always @(negedge clk) begin
        if (bus.o_char_valid) begin
            cvCount++;
            lastCvCycle = cycleCount;
        end
        if (bus.o_enter) enCount++;
        if (bus.o_backspace) bsCount++;
        if (bus.o_frame_err) errCount++;
        if ((int'(bus.o_char_valid) + int'(bus.o_enter) + int'(bus.o_backspace)) > 1) exclBad++;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    // Sends the first nBits bits of a frame: start, 8 data LSB first, parity, stop
    task automatic applyStimulus(input logic [7:0] b, input bit parOk, input bit stopOk, input int nBits);
        logic [10:0] bits;
        logic pb;
        logic sb;
        pb = parOk ? ~(^b) : (^b);
        sb = stopOk ? 1'b1 : 1'b0;
        bits = {sb, pb, b, 1'b0};
        for (int i = 0; i < nBits; i++) begin
            @(negedge clk);
            bus.i_ps2_dat = bits[i];
            repeat (HALF) @(negedge clk);
            bus.i_ps2_clk = 1'b0;
            if (i == 10) stopFallCycle = cycleCount;
            repeat (HALF) @(negedge clk);
            bus.i_ps2_clk = 1'b1;
        end
        @(negedge clk);
        bus.i_ps2_dat = 1'b1;
    endtask

    task automatic resetDut();
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    function automatic void addVec(input logic [7:0] s, input bit p, input bit st,
                                   input int cv, input int en, input int bs, input int er,
                                   input int ch, input int ls);
        vec_t v;
        v.scan = s; v.parOk = p; v.stopOk = st;
        v.dCv = cv; v.dEn = en; v.dBs = bs; v.dErr = er;
        v.expChar = ch; v.expLast = ls;
        vecs.push_back(v);
    endfunction

    initial begin
        #10_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c0, e0, b0, r0;

        //     scan  par stop cv en bs err char last
        addVec(8'h1C, 1, 1, 1, 0, 0, 0, 1,  8'h1C);
        addVec(8'h1C, 1, 1, 0, 0, 0, 0, 1,  8'h1C);
        addVec(8'h1C, 1, 1, 0, 0, 0, 0, 1,  8'h1C);
        addVec(8'hF0, 1, 1, 0, 0, 0, 0, 1,  8'hF0);
        addVec(8'h1C, 1, 1, 0, 0, 0, 0, 1,  8'h1C);
        addVec(8'h1C, 1, 1, 1, 0, 0, 0, 1,  8'h1C);
        addVec(8'hF0, 1, 1, 0, 0, 0, 0, 1,  8'hF0);
        addVec(8'h1C, 1, 1, 0, 0, 0, 0, 1,  8'h1C);
        addVec(8'hE0, 1, 1, 0, 0, 0, 0, 1,  8'hE0);
        addVec(8'h5A, 1, 1, 0, 0, 0, 0, 1,  8'h5A);
        addVec(8'hE0, 1, 1, 0, 0, 0, 0, 1,  8'hE0);
        addVec(8'hF0, 1, 1, 0, 0, 0, 0, 1,  8'hF0);
        addVec(8'h5A, 1, 1, 0, 0, 0, 0, 1,  8'h5A);
        addVec(8'h5A, 1, 1, 0, 1, 0, 0, 1,  8'h5A);
        addVec(8'hF0, 1, 1, 0, 0, 0, 0, 1,  8'hF0);
        addVec(8'h5A, 1, 1, 0, 0, 0, 0, 1,  8'h5A);
        addVec(8'h66, 1, 1, 0, 0, 1, 0, 1,  8'h66);
        addVec(8'h2D, 0, 1, 0, 0, 0, 1, 1,  8'h66);
        addVec(8'h2D, 1, 1, 1, 0, 0, 0, 18, 8'h2D);
        addVec(8'h32, 1, 1, 1, 0, 0, 0, 2,  8'h32);
        addVec(8'h4D, 1, 0, 0, 0, 0, 1, 2,  8'h32);
        addVec(8'h4D, 1, 1, 1, 0, 0, 0, 16, 8'h4D);
        addVec(8'h15, 1, 1, 1, 0, 0, 0, 17, 8'h15);
        addVec(8'h35, 1, 1, 1, 0, 0, 0, 25, 8'h35);
        addVec(8'h1D, 1, 1, 1, 0, 0, 0, 23, 8'h1D);
        addVec(8'h76, 1, 1, 0, 0, 0, 0, 23, 8'h76);
        addVec(8'h43, 1, 1, 1, 0, 0, 0, 9,  8'h43);
        addVec(8'h66, 1, 1, 0, 0, 1, 0, 9,  8'h66);
        addVec(8'h66, 1, 1, 0, 0, 0, 0, 9,  8'h66);
        addVec(8'hF0, 1, 1, 0, 0, 0, 0, 9,  8'hF0);
        addVec(8'h43, 1, 1, 0, 0, 0, 0, 9,  8'h43);
        addVec(8'h66, 1, 1, 0, 0, 0, 0, 9,  8'h66);
        addVec(8'h2A, 1, 1, 1, 0, 0, 0, 22, 8'h2A);

        bus.i_ps2_clk = 1'b1;
        bus.i_ps2_dat = 1'b1;
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("reset char_out", int'(bus.o_char_out), 0);
        checkOutput("reset last_scan", int'(bus.o_last_scan), 0);
        checkOutput("reset char_valid", int'(bus.o_char_valid), 0);
        checkOutput("reset frame_err", int'(bus.o_frame_err), 0);
        resetn = 1'b0;
        repeat (3) @(negedge clk);

        // First letter: pulse width, four-cycle latency from the stop-bit fall
        c0 = cvCount; r0 = errCount;
        applyStimulus(8'h1C, 1, 1, 11);
        repeat (6) @(negedge clk);
        checkOutput("t1 char_valid pulses", cvCount - c0, 1);
        checkOutput("t1 latency", lastCvCycle - stopFallCycle, 4);
        checkOutput("t1 char_out", int'(bus.o_char_out), 1);
        checkOutput("t1 last_scan", int'(bus.o_last_scan), 8'h1C);
        checkOutput("t1 frame_err", errCount - r0, 0);

        resetDut();
        foreach (vecs[i]) begin
            c0 = cvCount; e0 = enCount; b0 = bsCount; r0 = errCount;
            applyStimulus(vecs[i].scan, vecs[i].parOk, vecs[i].stopOk, 11);
            repeat (4) @(negedge clk);
            checkOutput($sformatf("vec%0d char_valid", i), cvCount - c0, vecs[i].dCv);
            checkOutput($sformatf("vec%0d enter", i), enCount - e0, vecs[i].dEn);
            checkOutput($sformatf("vec%0d backspace", i), bsCount - b0, vecs[i].dBs);
            checkOutput($sformatf("vec%0d frame_err", i), errCount - r0, vecs[i].dErr);
            checkOutput($sformatf("vec%0d char_out", i), int'(bus.o_char_out), vecs[i].expChar);
            checkOutput($sformatf("vec%0d last_scan", i), int'(bus.o_last_scan), vecs[i].expLast);
        end

        // Partial frame left hanging until the timeout aborts it
        c0 = cvCount; r0 = errCount;
        applyStimulus(8'h1A, 1, 1, 5);
        repeat (TIMEOUT - 100) @(negedge clk);
        checkOutput("t5 no early err", errCount - r0, 0);
        repeat (200) @(negedge clk);
        checkOutput("t5 timeout err", errCount - r0, 1);
        checkOutput("t5 no char", cvCount - c0, 0);
        r0 = errCount;
        applyStimulus(8'h1A, 1, 1, 11);
        repeat (4) @(negedge clk);
        checkOutput("t5 after char_out", int'(bus.o_char_out), 26);
        checkOutput("t5 after err", errCount - r0, 0);
        checkOutput("t5 after last_scan", int'(bus.o_last_scan), 8'h1A);

        // Reset in the middle of a frame
        c0 = cvCount; e0 = enCount; b0 = bsCount; r0 = errCount;
        applyStimulus(8'h43, 1, 1, 6);
        resetn = 1'b1;
        #1;
        checkOutput("t6 reset char_out", int'(bus.o_char_out), 0);
        checkOutput("t6 reset last_scan", int'(bus.o_last_scan), 0);
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("t6 no pulses", (cvCount - c0) + (enCount - e0) + (bsCount - b0) + (errCount - r0), 0);
        applyStimulus(8'h43, 1, 1, 11);
        repeat (4) @(negedge clk);
        checkOutput("t6 after char_out", int'(bus.o_char_out), 9);
        checkOutput("t6 after char_valid", cvCount - c0, 1);

        checkOutput("exclusive pulses", exclBad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
